// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and defaults for the FIFO stream reader.
// Occupancy is a 2-bit count of buffered words (0..2).
package fifo_stream_reader_pkg;
    localparam int unsigned DEF_WIDTH = 72;

    typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream bundle.
// master = reader engine, slave = FIFO and downstream side.
interface fifo_stream_reader_if
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] out_data;
    logic             out_vld;
    logic             out_rdy;
    occ_t             occupancy;

    modport master (
        input  fifo_dout, fifo_empty, out_rdy,
        output fifo_rd_en, out_data, out_vld, occupancy
    );

    modport slave (
        output fifo_dout, fifo_empty, out_rdy,
        input  fifo_rd_en, out_data, out_vld, occupancy
    );
endinterface

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry out/skid register pair; out register always holds the oldest word.
// Occupancy is registered alongside the data flags.
module stream_skid_reg
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             rdy_i,
    output logic [WIDTH-1:0] data_o,
    output logic             vld_o,
    output occ_t             occ_o
);
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             vld_q, vld_d;
    logic             skv_q, skv_d;
    occ_t             occ_q, occ_d;
    logic             pop;

    assign pop = vld_q & rdy_i;

    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        vld_d  = vld_q;
        skv_d  = skv_q;
        unique case (1'b1)
            !vld_q: begin
                vld_d = push_i;
                if (push_i) out_d = push_data_i;
            end
            pop && skv_q: begin
                out_d = skid_q;
                skv_d = push_i;
                if (push_i) skid_d = push_data_i;
            end
            pop && !skv_q: begin
                vld_d = push_i;
                if (push_i) out_d = push_data_i;
            end
            default: begin
                // Stalled: out holds, new word parks in skid.
                if (push_i) begin
                    skid_d = push_data_i;
                    skv_d  = 1'b1;
                end
            end
        endcase
        occ_d = {1'b0, vld_d} + {1'b0, skv_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            skid_q <= '0;
            vld_q  <= 1'b0;
            skv_q  <= 1'b0;
            occ_q  <= '0;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
            vld_q  <= vld_d;
            skv_q  <= skv_d;
            occ_q  <= occ_d;
        end
    end

    assign data_o = out_q;
    assign vld_o  = vld_q;
    assign occ_o  = occ_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO onto a valid/ready stream.
// Reads are issued on credit so buffered plus in-flight words never exceed 2.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    fifo_stream_reader_if.master bus
);
    logic       inflight_q, inflight_d;
    occ_t       held;
    logic       pop;
    logic [2:0] credit;

    assign pop    = bus.out_vld & bus.out_rdy;
    assign credit = {1'b0, held} + {2'b0, inflight_q} - {2'b0, pop};

    assign bus.fifo_rd_en = !reset & !bus.fifo_empty & (credit < 3'd2);
    assign inflight_d     = bus.fifo_rd_en;

    always_ff @(posedge clk) begin
        if (reset) inflight_q <= 1'b0;
        else       inflight_q <= inflight_d;
    end

    stream_skid_reg #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push_i     (inflight_q),
        .push_data_i(bus.fifo_dout),
        .rdy_i      (bus.out_rdy),
        .data_o     (bus.out_data),
        .vld_o      (bus.out_vld),
        .occ_o      (held)
    );

    assign bus.occupancy = held;

`ifndef SYNTHESIS
    a_credit: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, held} + {2'b0, inflight_q}) <= 3'd2);
    a_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.out_vld && !bus.out_rdy) |=> $stable(bus.out_data));
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: FIFO model, stream monitor, table-driven scenarios
// plus directed reset/latency sequences.
module tb_fifo_stream_reader;
    import fifo_stream_reader_pkg::*;

    typedef struct {
        logic [7:0] base;
        int         n;
        int         mode;
        int         stall;
        int         exp_rd_stall;
        int         exp_gap;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rdy = 1'b0;
    logic fclr = 1'b0;
    logic ld_go = 1'b0;
    logic [7:0] ld_base = '0;
    int ld_n = 0;
    logic wr_en = 1'b0;
    logic [71:0] wr_data = '0;
    logic [71:0] f_dout = '0;
    logic f_empty = 1'b1;

    logic [71:0] fq[$];
    logic [71:0] got[$];
    int pcyc[$];
    int cyc = 0;
    int rd_cnt = 0;
    int first_rd = -1;
    int first_vld = -1;
    int rd_empty_err = 0;
    int occ_err = 0;
    int stab_err = 0;
    logic stall_prev = 1'b0;
    logic [71:0] data_prev = '0;
    int checks = 0;
    int fails = 0;
    vec_t vecs[4];

    fifo_stream_reader_if #(.WIDTH(72)) bus ();

    assign bus.fifo_dout  = f_dout;
    assign bus.fifo_empty = f_empty;
    assign bus.out_rdy    = rdy;

    fifo_stream_reader #(
        .WIDTH(72)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-output FIFO: dout valid the cycle after rd_en.
    always @(posedge clk) begin
        if (fclr) begin
            fq.delete();
        end else begin
            if (bus.fifo_rd_en) begin
                if (fq.size() == 0) rd_empty_err++;
                else f_dout <= fq.pop_front();
            end
            if (ld_go)
                for (int i = 0; i < ld_n; i++)
                    fq.push_back(72'(ld_base) + 72'(i));
            if (wr_en) fq.push_back(wr_data);
        end
        f_empty <= (fq.size() == 0);
    end

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (bus.fifo_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (bus.out_vld && first_vld < 0) first_vld = cyc;
            if (bus.out_vld && bus.out_rdy) begin
                got.push_back(bus.out_data);
                pcyc.push_back(cyc);
            end
            if (bus.occupancy > 2'd2) occ_err++;
            if (stall_prev && bus.out_data != data_prev) stab_err++;
            stall_prev = bus.out_vld && !bus.out_rdy;
            data_prev  = bus.out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [71:0] a,
                       input logic [71:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, a, e);
        end
    endtask

    task automatic clr_mon();
        got.delete();
        pcyc.delete();
        rd_cnt = 0;
        first_rd = -1;
        first_vld = -1;
    endtask

    task automatic preload(input logic [7:0] base, input int n);
        ld_base = base;
        ld_n = n;
        ld_go = 1'b1;
        tick();
        ld_go = 1'b0;
    endtask

    task automatic drain_check(input logic [7:0] base, input int n,
                               input int mode, input int gap);
        int k = 0;
        int bad = 0;
        while (got.size() < n && k < 80) begin
            rdy = (mode == 1) ? ((k % 2) == 0) : 1'b1;
            tick();
            k++;
        end
        rdy = 1'b1;
        repeat (4) tick();
        rdy = 1'b0;
        chk("count", 72'(got.size()), 72'(n));
        chk("rd_pulses", 72'(rd_cnt), 72'(n));
        for (int i = 0; i < got.size(); i++)
            chk("data", got[i], 72'(base) + 72'(i));
        for (int i = 1; i < pcyc.size(); i++)
            if (pcyc[i] - pcyc[i-1] != gap) bad++;
        chk("gap", 72'(bad), 72'(0));
        chk("latency", 72'(first_vld - first_rd), 72'(2));
        @(negedge clk);
        chk("drained_vld", 72'(bus.out_vld), 72'(0));
        chk("drained_occ", 72'(bus.occupancy), 72'(0));
    endtask

    task automatic run_vec(input vec_t v);
        clr_mon();
        rdy = (v.mode == 0);
        preload(v.base, v.n);
        if (v.mode == 2) begin
            repeat (v.stall) tick();
            @(negedge clk);
            chk("stall_rd", 72'(rd_cnt), 72'(v.exp_rd_stall));
            chk("stall_occ", 72'(bus.occupancy), 72'(2));
            chk("stall_vld", 72'(bus.out_vld), 72'(1));
            chk("stall_data", bus.out_data, 72'(v.base));
            tick();
        end
        drain_check(v.base, v.n, v.mode, v.exp_gap);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h01, 8, 0, 0, 0, 1};
        vecs[1] = '{8'h10, 5, 2, 10, 2, 1};
        vecs[2] = '{8'h20, 6, 1, 0, 0, 2};
        vecs[3] = '{8'h40, 4, 0, 0, 0, 1};

        // Reset held while the FIFO already has words.
        tick();
        tick();
        preload(8'hE0, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_rd_en", 72'(bus.fifo_rd_en), 72'(0));
            chk("rst_vld", 72'(bus.out_vld), 72'(0));
            chk("rst_occ", 72'(bus.occupancy), 72'(0));
            tick();
        end
        clr_mon();
        reset = 1'b0;
        @(negedge clk);
        chk("first_rd_en", 72'(bus.fifo_rd_en), 72'(1));
        drain_check(8'hE0, 3, 0, 1);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Single word into an empty FIFO.
        clr_mon();
        rdy = 1'b0;
        wr_data = 72'h55;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        chk("single_rd_n", 72'(bus.fifo_rd_en), 72'(1));
        tick();
        @(negedge clk);
        chk("single_rd_n1", 72'(bus.fifo_rd_en), 72'(0));
        chk("single_vld_n1", 72'(bus.out_vld), 72'(0));
        tick();
        @(negedge clk);
        chk("single_vld_n2", 72'(bus.out_vld), 72'(1));
        chk("single_data", bus.out_data, 72'h55);
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        repeat (3) tick();
        chk("single_rd_cnt", 72'(rd_cnt), 72'(1));
        chk("single_count", 72'(got.size()), 72'(1));

        // Reset with buffer full, then with a word in flight.
        clr_mon();
        rdy = 1'b0;
        preload(8'h30, 8);
        for (int k = 0; k < 20 && bus.occupancy != 2'd2; k++) tick();
        chk("mid_occ", 72'(bus.occupancy), 72'(2));
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        reset = 1'b1;
        fclr = 1'b1;
        @(negedge clk);
        chk("mid_rst_rd_en", 72'(bus.fifo_rd_en), 72'(0));
        tick();
        reset = 1'b0;
        fclr = 1'b0;
        @(negedge clk);
        chk("post_rst_vld", 72'(bus.out_vld), 72'(0));
        chk("post_rst_occ", 72'(bus.occupancy), 72'(0));
        clr_mon();
        repeat (3) tick();
        @(negedge clk);
        chk("post_rst_idle_rd", 72'(rd_cnt), 72'(0));
        chk("post_rst_idle_vld", 72'(bus.out_vld), 72'(0));
        rdy = 1'b1;
        preload(8'hA0, 3);
        drain_check(8'hA0, 3, 0, 1);

        chk("rd_on_empty", 72'(rd_empty_err), 72'(0));
        chk("occ_range", 72'(occ_err), 72'(0));
        chk("stall_stable", 72'(stab_err), 72'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
